vx_rop_blend_elastic: RTL and testbench
=======================================

VX_ROP_BLEND_ELASTIC -- requirements
Module: VX_rop_blend_elastic

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of pixel lanes per transaction (1..16).
REQ-002 SHALL have parameter TAG_WIDTH, default 1: opaque tag width (>=1).
REQ-003 SHALL have parameter CHANNEL_BITS, default 8: bits per colour channel N (4..16).
REQ-004 SHALL have parameter LATENCY, default 3: input-accept to output-valid cycles (2..8).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1: the clock; all state changes on its rising edge.
REQ-007 reset  in  1: asynchronous, active-high reset.
REQ-008 valid_in  in  1; ready_in  out  1: input handshake.
REQ-009 tag_in  in  TAG_WIDTH; mask_in  in  NUM_LANES: per-lane blend enable.
REQ-010 mode_rgb  in  3; mode_a  in  3: per-transaction blend mode (0 ADD, 1 SUB, 2 REV_SUB, 3 MIN, 4 MAX, 5-7 PASS).
REQ-011 src_color, dst_color, src_factor, dst_factor  in  4*N*NUM_LANES each. Channel c of lane i is at bits [(4*i+c)*N +: N]; c=0 r, 1 g, 2 b, 3 a.
REQ-012 valid_out  out  1; ready_out  in  1: output handshake.
REQ-013 tag_out  out  TAG_WIDTH; mask_out  out  NUM_LANES; color_out  out  4*N*NUM_LANES.

Function
REQ-014 SHALL accept a transaction when valid_in && ready_in, and emit it when valid_out && ready_out.
REQ-015 SHALL capture mode_rgb, mode_a and mask_in with each transaction; later changes do not affect transactions already in flight.
REQ-016 SHALL compute, per channel with MAX = 2^N-1:
- norm(x) = (x + (x>>N) + 2^(N-1)) >> N.
- S = norm(src*src_factor); D = norm(dst*dst_factor).
- Products use a full 2N-bit width; the sum/difference uses N+1 bits.
REQ-017 SHALL produce channel results by mode:
- ADD = min(MAX, S+D).
- SUB = max(0, S-D).
- REV_SUB = max(0, D-S).
- MIN = min(src, dst) and MAX = max(src, dst); factors are ignored.
- PASS = dst.
REQ-018 SHALL apply mode_rgb to channels r, g, b and mode_a to channel a.
REQ-019 SHALL output dst_color unchanged for lanes with mask bit 0; mask_out equals the captured mask.
REQ-020 SHALL use an internal compute pipeline that never stalls, followed by an output FIFO of depth LATENCY+1 (first-word fall-through).
REQ-021 SHALL keep an occupancy counter (0..LATENCY+1) of transactions accepted but not yet emitted:
- +1 on accept only; -1 on emit only; unchanged when both happen in the same cycle.
REQ-022 ready_in SHALL equal (occupancy < LATENCY+1) && !reset, so the FIFO can never overflow.
REQ-023 With an empty block and ready_out held high, a transaction accepted in cycle t SHALL appear on valid_out in cycle t+LATENCY.
REQ-024 SHALL sustain one transaction per cycle indefinitely while ready_out stays high.
REQ-025 SHALL hold valid_out, tag_out, mask_out and color_out stable while valid_out && !ready_out.
REQ-026 SHALL emit transactions in acceptance order with the tag unmodified.
REQ-027 When full (occupancy = LATENCY+1) and an emit occurs, ready_in SHALL rise in the next cycle, not the same cycle.

Reset
REQ-028 Reset SHALL asynchronously clear:
- all pipeline valid bits;
- FIFO read/write pointers and count;
- the occupancy counter.
REQ-029 During reset and after it: valid_out = 0. ready_in = 0 while reset is high and 1 in the first cycle after release. Data registers are not reset.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transactions; none SHALL appear after release.

Verification
REQ-031 N=8, ADD, src=128, sf=255, dst=100, df=255, mask=1 -> color channel 228 at cycle t+3.
REQ-032 N=8, src=200, dst=100, all factors=255:
- ADD -> 255 (saturated).
- SUB -> 100.
- REV_SUB -> 0.
- MIN -> 100.
- MAX -> 200.
REQ-033 mode_rgb=ADD, mode_a=MIN, mask=4'b0101 -> lanes 1 and 3 equal dst_color; lanes 0 and 2 are blended, with alpha = min(src, dst).
REQ-034 Backpressure: ready_out=0 for 10 cycles with valid_in constantly high:
- exactly LATENCY+1 transactions are accepted, then ready_in=0;
- on release, all tags are emitted in order with no loss or duplication.
REQ-035 Continuous stream of 100 transactions with ready_out=1 -> 100 outputs on consecutive cycles; occupancy never exceeds LATENCY.
REQ-036 Reset pulse with 3 transactions in flight -> valid_out=0 immediately; no outputs after release; a new transaction completes at t+LATENCY.

Source files
------------

// File: rtl/vx_rop_blend_elastic_if.sv
// Handshake and data bundle for the elastic ROP blend unit.
// The master side drives transactions in and accepts results; the slave side is the blend unit.
interface vx_rop_blend_elastic_if #(
  parameter int NUM_LANES    = 4,
  parameter int TAG_WIDTH    = 1,
  parameter int CHANNEL_BITS = 8
);
  localparam int CW = 4 * CHANNEL_BITS * NUM_LANES;

  logic                 valid_in;
  logic                 ready_in;
  logic [TAG_WIDTH-1:0] tag_in;
  logic [NUM_LANES-1:0] mask_in;
  logic [2:0]           mode_rgb;
  logic [2:0]           mode_a;
  logic [CW-1:0]        src_color;
  logic [CW-1:0]        dst_color;
  logic [CW-1:0]        src_factor;
  logic [CW-1:0]        dst_factor;

  logic                 valid_out;
  logic                 ready_out;
  logic [TAG_WIDTH-1:0] tag_out;
  logic [NUM_LANES-1:0] mask_out;
  logic [CW-1:0]        color_out;

  modport master (
    output valid_in, tag_in, mask_in, mode_rgb, mode_a,
           src_color, dst_color, src_factor, dst_factor, ready_out,
    input  ready_in, valid_out, tag_out, mask_out, color_out
  );

  modport slave (
    input  valid_in, tag_in, mask_in, mode_rgb, mode_a,
           src_color, dst_color, src_factor, dst_factor, ready_out,
    output ready_in, valid_out, tag_out, mask_out, color_out
  );
endinterface

// File: rtl/vx_rop_blend_elastic.sv
// Elastic ROP blend: per-lane blend, fixed-latency non-stalling pipe, FWFT skid FIFO.
// Occupancy-based ready_in guarantees the FIFO absorbs everything the pipe can hold.
module vx_rop_blend_lane #(
  parameter int N = 8
) (
  input  logic           en_i,
  input  logic [2:0]     mode_rgb_i,
  input  logic [2:0]     mode_a_i,
  input  logic [4*N-1:0] src_i,
  input  logic [4*N-1:0] dst_i,
  input  logic [4*N-1:0] sf_i,
  input  logic [4*N-1:0] df_i,
  output logic [4*N-1:0] color_o
);
  localparam logic [N-1:0] MAX  = '1;
  localparam logic [2*N:0] HALF = {{(N+1){1'b0}}, 1'b1, {(N-1){1'b0}}};

  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic [N-1:0]   s, d, sf, df, r;
    logic [2*N-1:0] ps, pd;
    logic [2*N:0]   ts, td;
    logic [N:0]     ns, nd, sum;
    logic [2:0]     md;

    assign s  = src_i[c*N +: N];
    assign d  = dst_i[c*N +: N];
    assign sf = sf_i[c*N +: N];
    assign df = df_i[c*N +: N];
    assign ps = {{N{1'b0}}, s} * {{N{1'b0}}, sf};
    assign pd = {{N{1'b0}}, d} * {{N{1'b0}}, df};
    // x/MAX with rounding: (x + (x>>N) + half) >> N
    assign ts  = {1'b0, ps} + {{(N+1){1'b0}}, ps[2*N-1:N]} + HALF;
    assign td  = {1'b0, pd} + {{(N+1){1'b0}}, pd[2*N-1:N]} + HALF;
    assign ns  = (N+1)'(ts >> N);
    assign nd  = (N+1)'(td >> N);
    assign sum = ns + nd;
    assign md  = (c == 3) ? mode_a_i : mode_rgb_i;

    always_comb begin
      r = d;
      case (md)
        3'd0:    r = sum[N] ? MAX : sum[N-1:0];
        3'd1:    r = (ns > nd) ? N'(ns - nd) : '0;
        3'd2:    r = (nd > ns) ? N'(nd - ns) : '0;
        3'd3:    r = (s < d) ? s : d;
        3'd4:    r = (s > d) ? s : d;
        default: r = d;
      endcase
    end

    assign color_o[c*N +: N] = en_i ? r : d;
  end
endmodule

module vx_rop_blend_elastic #(
  parameter int NUM_LANES    = 4,
  parameter int TAG_WIDTH    = 1,
  parameter int CHANNEL_BITS = 8,
  parameter int LATENCY      = 3
) (
  input logic                    clk,
  input logic                    reset,
  vx_rop_blend_elastic_if.slave  bus
);
  localparam int N      = CHANNEL_BITS;
  localparam int LW     = 4 * N;
  localparam int CW     = LW * NUM_LANES;
  localparam int STAGES = LATENCY - 1;
  localparam int DEPTH  = LATENCY + 1;
  localparam int CNTW   = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [PW-1:0]   LAST_C  = PW'(DEPTH - 1);

  logic [CW-1:0] blend_w;
  logic          acc, emit, wr;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vx_rop_blend_lane #(.N(N)) u_lane (
      .en_i      (bus.mask_in[i]),
      .mode_rgb_i(bus.mode_rgb),
      .mode_a_i  (bus.mode_a),
      .src_i     (bus.src_color[i*LW +: LW]),
      .dst_i     (bus.dst_color[i*LW +: LW]),
      .sf_i      (bus.src_factor[i*LW +: LW]),
      .df_i      (bus.dst_factor[i*LW +: LW]),
      .color_o   (blend_w[i*LW +: LW])
    );
  end

  logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
  logic [TAG_WIDTH-1:0] tag_p_q  [1:STAGES];
  logic [NUM_LANES-1:0] mask_p_q [1:STAGES];
  logic [CW-1:0]        col_p_q  [1:STAGES];

  logic [TAG_WIDTH-1:0] tag_mem_q  [0:DEPTH-1];
  logic [NUM_LANES-1:0] mask_mem_q [0:DEPTH-1];
  logic [CW-1:0]        col_mem_q  [0:DEPTH-1];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      fcnt_q, fcnt_d, occ_q, occ_d;

  assign bus.ready_in = (occ_q < DEPTH_C) && !reset;
  assign acc  = bus.valid_in && bus.ready_in;
  assign bus.valid_out = (fcnt_q != '0);
  assign emit = bus.valid_out && bus.ready_out;
  assign wr   = vld_pipe_q[STAGES];

  assign bus.tag_out   = tag_mem_q[rd_ptr_q];
  assign bus.mask_out  = mask_mem_q[rd_ptr_q];
  assign bus.color_out = col_mem_q[rd_ptr_q];

  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[1] = acc;
    for (int k = 2; k <= STAGES; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    wr_ptr_d = wr ? ((wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = emit ? ((rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    fcnt_d = fcnt_q;
    case ({wr, emit})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    occ_d = occ_q;
    case ({acc, emit})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      occ_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      occ_q      <= occ_d;
    end
  end

  // Data path carries no reset; validity lives only in vld_pipe_q and the FIFO count.
  always_ff @(posedge clk) begin
    tag_p_q[1]  <= bus.tag_in;
    mask_p_q[1] <= bus.mask_in;
    col_p_q[1]  <= blend_w;
    for (int k = 2; k <= STAGES; k++) begin
      tag_p_q[k]  <= tag_p_q[k-1];
      mask_p_q[k] <= mask_p_q[k-1];
      col_p_q[k]  <= col_p_q[k-1];
    end
    if (wr) begin
      tag_mem_q[wr_ptr_q]  <= tag_p_q[STAGES];
      mask_mem_q[wr_ptr_q] <= mask_p_q[STAGES];
      col_mem_q[wr_ptr_q]  <= col_p_q[STAGES];
    end
  end
endmodule

// File: tb/tb_vx_rop_blend_elastic.sv
// Directed bench for vx_rop_blend_elastic: latency, blend modes, masking, backpressure,
// streaming throughput and mid-flight reset.
module tb_vx_rop_blend_elastic;
  localparam int NL  = 4;
  localparam int TW  = 8;
  localparam int N   = 8;
  localparam int LAT = 3;
  localparam int CW  = 4 * N * NL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_rop_blend_elastic_if #(.NUM_LANES(NL), .TAG_WIDTH(TW), .CHANNEL_BITS(N)) bus();

  vx_rop_blend_elastic #(.NUM_LANES(NL), .TAG_WIDTH(TW), .CHANNEL_BITS(N), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic [7:0] s, input logic [7:0] sf,
                        input logic [7:0] d, input logic [7:0] df);
    bus.src_color  = {16{s}};
    bus.src_factor = {16{sf}};
    bus.dst_color  = {16{d}};
    bus.dst_factor = {16{df}};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.valid_in = 1'b0; bus.ready_out = 1'b1; bus.tag_in = '0; bus.mask_in = '0;
    bus.mode_rgb = '0; bus.mode_a = '0;
    set_px(8'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    checks++; if (bus.ready_in !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.ready_in); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.valid_out); end
    reset = 1'b0;
    #1;
    checks++; if (bus.ready_in !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", bus.ready_in); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rel_valid got %b exp 0", bus.valid_out); end
    tick();
  endtask

  task automatic test_latency();
    logic [CW-1:0] exp_c;
    exp_c = {{4{8'd100}}, {4{8'd100}}, {4{8'd100}}, {4{8'd228}}};
    set_px(8'd128, 8'd255, 8'd100, 8'd255);
    bus.mode_rgb = 3'd0; bus.mode_a = 3'd0; bus.mask_in = 4'b0001; bus.tag_in = 8'h11;
    bus.valid_in = 1'b1;
    checks++; if (bus.ready_in !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", bus.ready_in); end
    tick();
    bus.valid_in = 1'b0;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL lat_t1 got %b exp 0", bus.valid_out); end
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL lat_t2 got %b exp 0", bus.valid_out); end
    tick();
    checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL lat_t3 got %b exp 1", bus.valid_out); end
    checks++; if (bus.tag_out !== 8'h11) begin errors++; $display("FAIL lat_tag got %h exp 11", bus.tag_out); end
    checks++; if (bus.mask_out !== 4'b0001) begin errors++; $display("FAIL lat_mask got %b exp 0001", bus.mask_out); end
    checks++; if (bus.color_out !== exp_c) begin errors++; $display("FAIL lat_color got %h exp %h", bus.color_out, exp_c); end
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL lat_drain got %b exp 0", bus.valid_out); end
  endtask

  task automatic test_modes();
    logic [7:0] exp_m [6];
    exp_m = '{8'd255, 8'd100, 8'd0, 8'd100, 8'd200, 8'd100};
    set_px(8'd200, 8'd255, 8'd100, 8'd255);
    bus.mask_in = 4'b1111;
    for (int m = 0; m < 6; m++) begin
      bus.mode_rgb = 3'(m); bus.mode_a = 3'(m); bus.tag_in = 8'(8'h20 + m);
      bus.valid_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      tick(); tick();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.color_out !== {16{exp_m[m]}}) begin
        errors++;
        $display("FAIL mode%0d got v=%b %h exp %h", m, bus.valid_out, bus.color_out, {16{exp_m[m]}});
      end
      tick();
    end
  endtask

  task automatic test_mixed();
    logic [CW-1:0] exp_c;
    logic [31:0] on_l, off_l;
    on_l  = {8'd60, 8'd160, 8'd160, 8'd160};
    off_l = {4{8'd100}};
    exp_c = {off_l, on_l, off_l, on_l};
    set_px(8'd60, 8'd255, 8'd100, 8'd255);
    bus.mode_rgb = 3'd0; bus.mode_a = 3'd3; bus.mask_in = 4'b0101; bus.tag_in = 8'h22;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.mode_rgb = 3'd5; bus.mode_a = 3'd0; bus.mask_in = 4'b1111;
    tick(); tick();
    checks++; if (bus.color_out !== exp_c) begin errors++; $display("FAIL mixed_color got %h exp %h", bus.color_out, exp_c); end
    checks++; if (bus.mask_out !== 4'b0101) begin errors++; $display("FAIL mixed_mask got %b exp 0101", bus.mask_out); end
    checks++; if (bus.tag_out !== 8'h22) begin errors++; $display("FAIL mixed_tag got %h exp 22", bus.tag_out); end
    tick();
  endtask

  task automatic test_backpressure();
    int n_acc, got;
    logic acc;
    logic [7:0] nt;
    n_acc = 0; got = 0; nt = 8'h40;
    bus.mode_rgb = 3'd5; bus.mode_a = 3'd5; bus.mask_in = 4'b1111;
    bus.ready_out = 1'b0; bus.valid_in = 1'b1; bus.tag_in = nt;
    for (int k = 0; k < 10; k++) begin
      acc = bus.valid_in && bus.ready_in;
      tick();
      if (acc) begin n_acc++; nt++; bus.tag_in = nt; end
    end
    checks++; if (n_acc != LAT + 1) begin errors++; $display("FAIL bp_accepts got %0d exp %0d", n_acc, LAT + 1); end
    checks++; if (bus.ready_in !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.ready_in); end
    checks++; if (bus.valid_out !== 1'b1 || bus.tag_out !== 8'h40) begin
      errors++; $display("FAIL bp_hold got v=%b tag=%h exp v=1 tag=40", bus.valid_out, bus.tag_out); end
    bus.valid_in = 1'b0; bus.ready_out = 1'b1;
    #1;
    checks++; if (bus.ready_in !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_ready got %b exp 0", bus.ready_in); end
    for (int k = 0; k < 20; k++) begin
      if (bus.valid_out === 1'b1) begin
        checks++;
        if (bus.tag_out !== 8'(8'h40 + got)) begin
          errors++; $display("FAIL bp_order got %h exp %h", bus.tag_out, 8'(8'h40 + got)); end
        got++;
      end
      tick();
      if (k == 0) begin
        checks++; if (bus.ready_in !== 1'b1) begin errors++; $display("FAIL bp_next_ready got %b exp 1", bus.ready_in); end
      end
    end
    checks++; if (got != LAT + 1) begin errors++; $display("FAIL bp_drain_count got %0d exp %0d", got, LAT + 1); end
  endtask

  task automatic test_back_to_back();
    bus.mode_rgb = 3'd5; bus.mode_a = 3'd5; bus.mask_in = 4'b1111; bus.ready_out = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (cyc < 100) begin
        bus.valid_in = 1'b1; bus.tag_in = 8'(cyc); bus.dst_color = {16{8'(cyc)}};
        checks++; if (bus.ready_in !== 1'b1) begin errors++; $display("FAIL stream_ready cyc %0d got %b exp 1", cyc, bus.ready_in); end
      end else begin
        bus.valid_in = 1'b0;
      end
      checks++;
      if (cyc >= LAT && cyc < 100 + LAT) begin
        if (bus.valid_out !== 1'b1 || bus.tag_out !== 8'(cyc - LAT) || bus.color_out !== {16{8'(cyc - LAT)}}) begin
          errors++;
          $display("FAIL stream_out cyc %0d got v=%b tag=%h exp v=1 tag=%h", cyc, bus.valid_out, bus.tag_out, 8'(cyc - LAT));
        end
      end else if (bus.valid_out !== 1'b0) begin
        errors++; $display("FAIL stream_idle cyc %0d got %b exp 0", cyc, bus.valid_out);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    seen = 1'b0;
    bus.ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.valid_in = 1'b1; bus.tag_in = 8'(8'h80 + k);
      tick();
    end
    bus.valid_in = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.valid_out); end
    checks++; if (bus.ready_in !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", bus.ready_in); end
    tick(); tick();
    reset = 1'b0; bus.ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (bus.valid_out !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_ghost got %b exp 0", seen); end
    bus.valid_in = 1'b1; bus.tag_in = 8'h90;
    tick();
    bus.valid_in = 1'b0;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL mid_t1 got %b exp 0", bus.valid_out); end
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL mid_t2 got %b exp 0", bus.valid_out); end
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.tag_out !== 8'h90) begin
      errors++; $display("FAIL mid_t3 got v=%b tag=%h exp v=1 tag=90", bus.valid_out, bus.tag_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_mixed();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
